// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
package vend_pkg;

   localparam int unsigned CREDIT_W    = 8;
   localparam int unsigned SUM_W       = CREDIT_W + 1;

   localparam int unsigned COIN_10_VAL = 1;
   localparam int unsigned COIN_20_VAL = 2;
   localparam int unsigned COIN_50_VAL = 5;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      VEND,
      RETURN
   } state_t;

endpackage

// File: rtl/vend_pacer.sv
// Change-return pacer: ticks on the first enabled cycle, then every CHG_GAP cycles.
module vend_pacer #(
   parameter int unsigned CHG_GAP = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = (CHG_GAP > 1) ? $clog2(CHG_GAP) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CHG_GAP - 1);

   logic [CNT_W-1:0] cnt;
   logic             en_q;

   // A rising enable restarts the cadence regardless of the leftover count.
   assign tick_c = en && (!en_q || (cnt == '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= en;
         if (!en) begin
            cnt <= '0;
         end else if (tick_c) begin
            cnt <= RELOAD;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: credit tracking, dispense hold and paced change return.
// Optional sales counter output enabled by defining VEND_SALES_CNT_EN.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE       = 6,
   parameter int unsigned CREDIT_MAX  = 15,
   parameter int unsigned DISP_CYCLES = 4,
   parameter int unsigned CHG_GAP     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_10,
   input  logic       coin_20,
   input  logic       coin_50,
   input  logic       vend,
   input  logic       cancel,
   output logic [7:0] credit,
   output logic       dispense,
   output logic       change_out,
   output logic       coin_reject,
   output logic       low_credit,
`ifdef VEND_SALES_CNT_EN
   output logic [15:0] sales_cnt,
`endif
   output logic       busy
);

   localparam int unsigned DISP_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [DISP_W-1:0]   DISP_LAST    = DISP_W'(DISP_CYCLES - 1);
   localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
   localparam logic [SUM_W-1:0]    CREDIT_MAX_C = SUM_W'(CREDIT_MAX);

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [DISP_W-1:0]   disp_cnt, disp_cnt_nxt;
   logic                dispense_nxt;
   logic                reject_nxt;
   logic                low_nxt;
   logic                coin_any_c;
   logic [SUM_W-1:0]    coin_sum_c;
   logic [SUM_W-1:0]    credit_sum_c;
   logic                pacer_en_c;
   logic                pacer_tick_c;

   assign coin_any_c   = coin_10 | coin_20 | coin_50;
   assign coin_sum_c   = SUM_W'(coin_10) * SUM_W'(COIN_10_VAL)
                       + SUM_W'(coin_20) * SUM_W'(COIN_20_VAL)
                       + SUM_W'(coin_50) * SUM_W'(COIN_50_VAL);
   assign credit_sum_c = SUM_W'(credit) + coin_sum_c;

   // Pacer runs on the cycle before each RETURN cycle so change_out lands in RETURN.
   assign pacer_en_c = (state_nxt == RETURN);

   vend_pacer #(
      .CHG_GAP (CHG_GAP)
   ) u_pacer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (pacer_en_c),
      .tick_c (pacer_tick_c)
   );

   always_comb begin
      state_nxt    = state;
      credit_nxt   = credit;
      disp_cnt_nxt = disp_cnt;
      dispense_nxt = 1'b0;
      reject_nxt   = 1'b0;
      low_nxt      = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (cancel && (credit != '0)) begin
               state_nxt  = RETURN;
               reject_nxt = coin_any_c;
            end else if (vend && (credit >= PRICE_C)) begin
               state_nxt    = VEND;
               credit_nxt   = credit - PRICE_C;
               dispense_nxt = 1'b1;
               disp_cnt_nxt = DISP_LAST;
               reject_nxt   = coin_any_c;
            end else begin
               low_nxt = vend;
               if (coin_any_c) begin
                  if (credit_sum_c <= CREDIT_MAX_C) begin
                     credit_nxt = credit_sum_c[CREDIT_W-1:0];
                     state_nxt  = COLLECT;
                  end else begin
                     reject_nxt = 1'b1;
                  end
               end
            end
         end
         VEND: begin
            reject_nxt = coin_any_c;
            if (disp_cnt != '0) begin
               dispense_nxt = 1'b1;
               disp_cnt_nxt = disp_cnt - DISP_W'(1);
            end else begin
               state_nxt = (credit != '0) ? RETURN : IDLE;
            end
         end
         RETURN: begin
            reject_nxt = coin_any_c;
            // The registered pulse drives the decrement on the following edge.
            if (change_out && (credit != '0)) begin
               credit_nxt = credit - CREDIT_W'(1);
               if (credit == CREDIT_W'(1)) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         credit      <= '0;
         disp_cnt    <= '0;
         dispense    <= 1'b0;
         change_out  <= 1'b0;
         coin_reject <= 1'b0;
         low_credit  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         disp_cnt    <= disp_cnt_nxt;
         dispense    <= dispense_nxt;
         change_out  <= pacer_tick_c;
         coin_reject <= reject_nxt;
         low_credit  <= low_nxt;
         busy        <= (state_nxt == VEND) || (state_nxt == RETURN);
      end
   end

`ifdef VEND_SALES_CNT_EN
   logic sale_c;

   assign sale_c = (state_nxt == VEND) && (state != VEND);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sales_cnt <= '0;
      end else if (sale_c) begin
         sales_cnt <= sales_cnt + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed-vector bench for vend_ctrl with PRICE=6, CREDIT_MAX=15, DISP_CYCLES=4, CHG_GAP=3.
module tb_vend_ctrl;

   logic       clk;
   logic       rst_n;
   logic       coin_10, coin_20, coin_50, vend, cancel;
   logic [7:0] credit;
   logic       dispense, change_out, coin_reject, low_credit, busy;
`ifdef VEND_SALES_CNT_EN
   logic [15:0] sales_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // stim = {coin_10, coin_20, coin_50, vend, cancel}; out = {dispense, change_out, coin_reject, low_credit, busy}
   typedef struct {
      logic       rst_n;
      logic [4:0] stim;
      logic [7:0] exp_credit;
      logic [4:0] exp_out;
   } vec_t;

   vec_t vecs[$];

   localparam logic [4:0] NO  = 5'b00000;
   localparam logic [4:0] C10 = 5'b10000;
   localparam logic [4:0] C20 = 5'b01000;
   localparam logic [4:0] C50 = 5'b00100;
   localparam logic [4:0] VND = 5'b00010;
   localparam logic [4:0] CAN = 5'b00001;
   localparam logic [4:0] DSP = 5'b10000;
   localparam logic [4:0] CHG = 5'b01000;
   localparam logic [4:0] REJ = 5'b00100;
   localparam logic [4:0] LOW = 5'b00010;
   localparam logic [4:0] BSY = 5'b00001;

   vend_ctrl #(
      .PRICE       (6),
      .CREDIT_MAX  (15),
      .DISP_CYCLES (4),
      .CHG_GAP     (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .coin_10     (coin_10),
      .coin_20     (coin_20),
      .coin_50     (coin_50),
      .vend        (vend),
      .cancel      (cancel),
      .credit      (credit),
      .dispense    (dispense),
      .change_out  (change_out),
      .coin_reject (coin_reject),
      .low_credit  (low_credit),
`ifdef VEND_SALES_CNT_EN
      .sales_cnt   (sales_cnt),
`endif
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [4:0] s, input int c, input logic [4:0] o);
      vec_t v;
      v.rst_n      = r;
      v.stim       = s;
      v.exp_credit = 8'(c);
      v.exp_out    = o;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [4:0] s);
      rst_n = r;
      {coin_10, coin_20, coin_50, vend, cancel} = s;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int pulses;
   int last;

   initial begin
      drive(1'b0, NO);

      // Exact price: 5 + 1, vend, four dispense cycles, no change
      add(0, NO, 0, NO);
      add(1, NO, 0, NO);
      add(1, C50, 5, NO);
      add(1, NO, 5, NO);
      add(1, C10, 6, NO);
      add(1, VND, 0, DSP | BSY);
      add(1, NO, 0, DSP | BSY);
      add(1, NO, 0, DSP | BSY);
      add(1, NO, 0, DSP | BSY);
      add(1, NO, 0, NO);
      add(1, NO, 0, NO);
      // Change: credit 10, vend, then 4 paced pulses; coins/vend/cancel during RETURN
      add(1, C50, 5, NO);
      add(1, C50, 10, NO);
      add(1, VND, 4, DSP | BSY);
      add(1, NO, 4, DSP | BSY);
      add(1, NO, 4, DSP | BSY);
      add(1, NO, 4, DSP | BSY);
      add(1, NO, 4, CHG | BSY);
      add(1, NO, 3, BSY);
      add(1, C50, 3, REJ | BSY);
      add(1, NO, 3, CHG | BSY);
      add(1, VND, 2, BSY);
      add(1, CAN, 2, BSY);
      add(1, NO, 2, CHG | BSY);
      add(1, NO, 1, BSY);
      add(1, NO, 1, BSY);
      add(1, NO, 1, CHG | BSY);
      add(1, NO, 0, NO);
      add(1, NO, 0, NO);
      // Simultaneous coins and the CREDIT_MAX boundary
      add(1, C10 | C20 | C50, 8, NO);
      add(1, C50, 13, NO);
      add(1, C50, 13, REJ);
      add(1, NO, 13, NO);
      add(1, C20, 15, NO);
      add(1, C10, 15, REJ);
      add(0, NO, 0, NO);
      // Vend beats coins; coins and vend during VEND
      add(1, C50, 5, NO);
      add(1, C20, 7, NO);
      add(1, VND | C20, 1, DSP | REJ | BSY);
      add(1, C10, 1, DSP | REJ | BSY);
      add(1, VND, 1, DSP | BSY);
      add(1, NO, 1, DSP | BSY);
      add(1, NO, 1, CHG | BSY);
      add(1, NO, 0, NO);
      // Low credit, then cancel beating vend at credit 3
      add(1, C20, 2, NO);
      add(1, C10, 3, NO);
      add(1, VND, 3, LOW);
      add(1, NO, 3, NO);
      add(1, CAN | VND, 3, CHG | BSY);
      add(1, NO, 2, BSY);
      add(1, NO, 2, BSY);
      add(1, NO, 2, CHG | BSY);
      add(1, NO, 1, BSY);
      add(1, NO, 1, BSY);
      add(1, NO, 1, CHG | BSY);
      add(1, NO, 0, NO);
      // Cancel at zero credit is ignored; low_credit still accepts coins
      add(1, CAN, 0, NO);
      add(1, CAN | C10, 1, NO);
      add(1, VND | C10, 2, LOW);
      add(0, NO, 0, NO);
      // Reset right after the first change pulse
      add(1, C20, 2, NO);
      add(1, C20, 4, NO);
      add(1, CAN, 4, CHG | BSY);
      add(0, NO, 0, NO);
      add(1, NO, 0, NO);
      add(1, NO, 0, NO);
      add(1, NO, 0, NO);
      add(1, NO, 0, NO);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].stim);
         tick();
         check("row", i,
               32'({credit, dispense, change_out, coin_reject, low_credit, busy}),
               32'({vecs[i].exp_credit, vecs[i].exp_out}));
      end

      // Refund of 10 units: pulse count, spacing and release of busy
      drive(1'b1, C50);
      tick();
      drive(1'b1, C50);
      tick();
      check("pre_cancel_credit", 0, 32'(credit), 32'd10);
      drive(1'b1, CAN);
      tick();
      drive(1'b1, NO);
      check("first_chg", 0, 32'(change_out), 32'd1);
      pulses = 1;
      last   = 1;
      for (int t = 2; t <= 60; t++) begin
         tick();
         if (change_out) begin
            check("chg_gap", pulses, 32'(t - last), 32'd3);
            pulses++;
            last = t;
         end
      end
      check("chg_count", 0, 32'(pulses), 32'd10);
      check("end_busy", 0, 32'(busy), 32'd0);
      check("end_credit", 0, 32'(credit), 32'd0);

`ifdef VEND_SALES_CNT_EN
      drive(1'b0, NO);
      tick();
      check("sales_reset", 0, 32'(sales_cnt), 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, C50 | C10);
         tick();
         drive(1'b1, VND);
         tick();
         drive(1'b1, NO);
         check("sales_step", k, 32'(sales_cnt), 32'(k + 1));
         repeat (5) @(posedge clk);
         #1;
      end
      drive(1'b1, VND);
      tick();
      drive(1'b1, NO);
      check("sales_low", 0, 32'(low_credit), 32'd1);
      tick();
      check("sales_total", 0, 32'(sales_cnt), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
